// File: rtl/pc_stack.sv
// Program counter with an integrated LIFO return-address stack for the Hack CPU.
// Supports reset/load/increment/hold, plus call (push out+1) and return (pop to out).
module pc_stack #(
    parameter int unsigned      WIDTH       = 16,
    parameter int unsigned      DEPTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           in,
    input  logic                       load,
    input  logic                       inc,
    input  logic                       push,
    input  logic                       pop,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             empty_s, full_s;
    logic [CW-1:0]    top_pos_s;
    logic [WIDTH-1:0] top_s;
    logic [WIDTH-1:0] ret_addr_s;
    logic             wr_en_s;
    logic [AW-1:0]    wr_idx_s;

    assign empty_s    = (count_q == '0);
    assign full_s     = (count_q == CW'(DEPTH));
    assign top_pos_s  = count_q - CW'(1);
    assign top_s      = stack_q[top_pos_s[AW-1:0]];
    assign ret_addr_s = out_q + WIDTH'(1);

    // Next-state decode for address, stack pointer, error flags and stack write port
    always_comb begin
        out_d    = out_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        wr_en_s  = 1'b0;
        wr_idx_s = count_q[AW-1:0];
        if (push && pop && !empty_s) begin
            // Return and call in one cycle: swap the top entry in place
            out_d    = top_s;
            wr_en_s  = 1'b1;
            wr_idx_s = top_pos_s[AW-1:0];
        end else begin
            if (pop && !empty_s) begin
                out_d   = top_s;
                count_d = count_q - CW'(1);
            end else begin
                if (pop) begin
                    unf_d = 1'b1;
                end else begin
                    unf_d = unf_q;
                end
                if (load) begin
                    out_d = in;
                end else if (inc) begin
                    out_d = ret_addr_s;
                end else begin
                    out_d = out_q;
                end
            end
            if (push && !full_s) begin
                wr_en_s = 1'b1;
                count_d = count_q + CW'(1);
            end else if (push) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end
    end

    // Address, occupancy and sticky error registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= RESET_VALUE;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage; contents are meaningless after reset so no clear is needed
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_s) begin
            stack_q[wr_idx_s] <= ret_addr_s;
        end
    end

    assign out       = out_q;
    assign count     = count_q;
    assign empty     = empty_s;
    assign full      = full_s;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Bench for pc_stack (WIDTH=16, DEPTH=4): directed vector table, a call/return
// sequence, then randomized traffic checked against a queue-based reference model.
module tb_pc_stack;

    logic        clk;
    logic        rst_n;
    logic [15:0] t_in;
    logic        t_load, t_inc, t_push, t_pop;
    logic [15:0] t_out;
    logic [2:0]  t_count;
    logic        t_empty, t_full, t_ovf, t_unf;

    int errors = 0;
    int checks = 0;

    pc_stack #(.WIDTH(16), .DEPTH(4), .RESET_VALUE(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .in(t_in), .load(t_load), .inc(t_inc),
        .push(t_push), .pop(t_pop), .out(t_out), .count(t_count),
        .empty(t_empty), .full(t_full), .overflow(t_ovf), .underflow(t_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: the stack is a queue, back is the top
    logic [15:0] m_out;
    logic [15:0] m_stk [$];
    logic        m_ovf, m_unf;

    task automatic model_step(input logic r, input logic [15:0] i, input logic ld,
                              input logic ic, input logic pu, input logic po);
        logic [15:0] old;
        old = m_out;
        if (!r) begin
            m_out = 16'h0000;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (pu && po && m_stk.size() > 0) begin
            m_out = m_stk[m_stk.size() - 1];
            m_stk[m_stk.size() - 1] = old + 16'd1;
        end else begin
            if (po && m_stk.size() > 0) begin
                m_out = m_stk.pop_back();
            end else begin
                if (po) m_unf = 1'b1;
                m_out = ld ? i : (ic ? old + 16'd1 : old);
            end
            if (pu) begin
                if (m_stk.size() == 4) m_ovf = 1'b1;
                else m_stk.push_back(old + 16'd1);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, clock once, then compare against the model
    task automatic step(input logic r, input logic [15:0] i, input logic ld,
                        input logic ic, input logic pu, input logic po);
        @(negedge clk);
        rst_n = r; t_in = i; t_load = ld; t_inc = ic; t_push = pu; t_pop = po;
        @(posedge clk);
        model_step(r, i, ld, ic, pu, po);
        #1;
        check("model_out",   32'(t_out),   32'(m_out));
        check("model_count", 32'(t_count), 32'(m_stk.size()));
        check("model_empty", 32'(t_empty), 32'(m_stk.size() == 0));
        check("model_full",  32'(t_full),  32'(m_stk.size() == 4));
        check("model_ovf",   32'(t_ovf),   32'(m_ovf));
        check("model_unf",   32'(t_unf),   32'(m_unf));
    endtask

    typedef struct {
        logic        r;
        logic [15:0] i;
        logic        ld, ic, pu, po;
        logic [15:0] e_out;
        int          e_cnt;
        logic        e_ovf, e_unf;
    } vec_t;

    vec_t vecs [$];

    function automatic void add(input logic r, input logic [15:0] i, input logic ld,
                                input logic ic, input logic pu, input logic po,
                                input logic [15:0] eo, input int ec,
                                input logic eov, input logic eun);
        vec_t v;
        v.r = r; v.i = i; v.ld = ld; v.ic = ic; v.pu = pu; v.po = po;
        v.e_out = eo; v.e_cnt = ec; v.e_ovf = eov; v.e_unf = eun;
        vecs.push_back(v);
    endfunction

    initial begin
        rst_n = 1'b0; t_in = 16'h0; t_load = 1'b0; t_inc = 1'b0; t_push = 1'b0; t_pop = 1'b0;
        m_out = 16'h0; m_ovf = 1'b0; m_unf = 1'b0;

        //   r  in        ld    ic    pu    po     out       cnt ovf   unf
        add(0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 0, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 0, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0003, 0, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0003, 0, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0003, 0, 1'b0, 1'b0);
        add(1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 0, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0);
        add(1, 16'd5,    1'b1, 1'b0, 1'b0, 1'b0, 16'd5,    0, 1'b0, 1'b0);
        add(1, 16'd100,  1'b1, 1'b0, 1'b1, 1'b0, 16'd100,  1, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'd101,  1, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'd102,  1, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd6,    0, 1'b0, 1'b0);
        add(0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,    0, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1,    1, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2,    2, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3,    3, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'd4,    4, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'd5,    4, 1'b1, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4,    3, 1'b1, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3,    2, 1'b1, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2,    1, 1'b1, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1,    0, 1'b1, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1,    0, 1'b1, 1'b1);
        add(0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0,    0, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0,    1, 1'b0, 1'b0);
        add(1, 16'd19,   1'b1, 1'b0, 1'b0, 1'b0, 16'd19,   1, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'd19,   2, 1'b0, 1'b0);
        add(1, 16'd50,   1'b1, 1'b0, 1'b0, 1'b0, 16'd50,   2, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'd20,   2, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd51,   1, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1,    0, 1'b0, 1'b0);
        add(1, 16'd7,    1'b1, 1'b0, 1'b0, 1'b0, 16'd7,    0, 1'b0, 1'b0);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'd7,    1, 1'b0, 1'b1);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd8,    0, 1'b0, 1'b1);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'd8,    1, 1'b0, 1'b1);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'd8,    2, 1'b0, 1'b1);
        add(1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'd8,    3, 1'b0, 1'b1);
        add(1, 16'd9,    1'b1, 1'b0, 1'b0, 1'b0, 16'd9,    3, 1'b0, 1'b1);
        add(0, 16'd44,   1'b1, 1'b0, 1'b1, 1'b1, 16'd0,    0, 1'b0, 1'b0);

        foreach (vecs[k]) begin
            step(vecs[k].r, vecs[k].i, vecs[k].ld, vecs[k].ic, vecs[k].pu, vecs[k].po);
            check($sformatf("vec%0d_out", k),   32'(t_out),   32'(vecs[k].e_out));
            check($sformatf("vec%0d_count", k), 32'(t_count), 32'(vecs[k].e_cnt));
            check($sformatf("vec%0d_empty", k), 32'(t_empty), 32'(vecs[k].e_cnt == 0));
            check($sformatf("vec%0d_full", k),  32'(t_full),  32'(vecs[k].e_cnt == 4));
            check($sformatf("vec%0d_ovf", k),   32'(t_ovf),   32'(vecs[k].e_ovf));
            check($sformatf("vec%0d_unf", k),   32'(t_unf),   32'(vecs[k].e_unf));
        end

        // Back-to-back call then return: value pushed at one edge is popped at the next
        step(1'b1, 16'd30,  1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'd200, 1'b1, 1'b0, 1'b1, 1'b0);
        check("b2b_call_out",   32'(t_out),   32'd200);
        check("b2b_call_count", 32'(t_count), 32'd1);
        step(1'b1, 16'd0,   1'b0, 1'b0, 1'b0, 1'b1);
        check("b2b_ret_out",    32'(t_out),   32'd31);
        check("b2b_ret_count",  32'(t_count), 32'd0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            logic        r;
            logic [15:0] i;
            r = ($urandom_range(0, 63) != 0);
            i = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            step(r, i, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
